// File: rtl/ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_arbiter: four-requester SDRAM command arbiter with in-order read     |
// | return routing.                                            Revision 1.0  |
// +--------------------------------------------------------------------------+
module ram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 128,
  parameter int RD_DEPTH  = 4,
  parameter int ISSUE_GAP = 2
) (
  input  logic              clk_133M,
  input  logic              rst_133M,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_address,
  input  logic [DATA_W-1:0] cam_wr_data,
  input  logic              hdr_wr_req,
  input  logic [ADDR_W-1:0] hdr_wr_address,
  input  logic [DATA_W-1:0] hdr_wr_data,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_address,
  input  logic              ram_busy,
  input  logic              ram_rd_valid,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              err_clr,
  output logic              cmd_req,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_address,
  output logic [DATA_W-1:0] cmd_data,
  output logic [3:0]        grant,
  output logic              hdr_rd_valid,
  output logic [DATA_W-1:0] hdr_rd_data,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic [3:0]        pending,
  output logic [3:0]        overflow,
  output logic              rd_underflow
);

  localparam int PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RD_DEPTH) + 1;
  localparam int HOLD_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RD_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        rr_ptr;
  logic [3:0]        grant_q;
  logic [3:0]        req;
  logic [3:0]        granted;
  logic [3:0]        accept;
  logic [3:0]        eligible;
  logic              rd_ok;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic [2:0]        rr_sum;
  logic              load;
  logic [ADDR_W-1:0] req_addr  [4];
  logic [ADDR_W-1:0] slot_addr [4];
  logic [DATA_W-1:0] slot_data [2];

  logic              tags [RD_DEPTH];
  logic [PTR_W-1:0]  tag_wr_ptr, tag_rd_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic              push, pop, pop_tag;

  assign req         = {vga_rd_req, hdr_rd_req, hdr_wr_req, cam_wr_req};
  assign req_addr[0] = cam_wr_address;
  assign req_addr[1] = hdr_wr_address;
  assign req_addr[2] = hdr_rd_address;
  assign req_addr[3] = vga_rd_address;

  assign cmd_req = (state == ST_ISSUE);
  assign granted = cmd_req ? grant_q : 4'b0000;
  assign grant   = granted;
  // A pulse on a slot being granted this cycle refills it instead of overflowing.
  assign accept  = req & (~pending | granted);
  assign rd_ok   = (tag_cnt < DEPTH_C);

  assign push    = cmd_req & (grant_q[2] | grant_q[3]);
  assign pop     = ram_rd_valid & (tag_cnt != '0);
  assign pop_tag = tags[tag_rd_ptr];

  always_comb begin
    eligible  = pending & {rd_ok, rd_ok, 2'b11};
    win_valid = 1'b0;
    win_idx   = 2'd0;
    rr_sum    = 3'd0;
    if (eligible[0]) begin
      win_valid = 1'b1;
    end else begin
      // rr_ptr indexes slots 1..3 as 0..2
      for (int k = 0; k < 3; k++) begin
        rr_sum = {1'b0, rr_ptr} + 3'(k);
        if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
        if (!win_valid && eligible[rr_sum[1:0] + 2'd1]) begin
          win_valid = 1'b1;
          win_idx   = rr_sum[1:0] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ram_busy && win_valid) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_HOLD;
      ST_HOLD:  if (hold_cnt == HOLD_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_ISSUE)     hold_cnt <= '0;
      else if (state == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      grant_q     <= 4'b0000;
      cmd_we      <= 1'b0;
      cmd_address <= '0;
      cmd_data    <= '0;
      rr_ptr      <= 2'd0;
    end else if (load) begin
      grant_q     <= 4'b0001 << win_idx;
      cmd_we      <= ~win_idx[1];
      cmd_address <= slot_addr[win_idx];
      cmd_data    <= win_idx[1] ? '0 : slot_data[win_idx[0]];
      if (win_idx != 2'd0) rr_ptr <= (win_idx == 2'd3) ? 2'd0 : win_idx;
    end
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      pending  <= 4'b0000;
      overflow <= 4'b0000;
      for (int i = 0; i < 4; i++) slot_addr[i] <= '0;
      for (int i = 0; i < 2; i++) slot_data[i] <= '0;
    end else begin
      overflow <= (err_clr ? 4'b0000 : overflow) | (req & pending & ~granted);
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          pending[i]   <= 1'b1;
          slot_addr[i] <= req_addr[i];
        end else if (granted[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (accept[0]) slot_data[0] <= cam_wr_data;
      if (accept[1]) slot_data[1] <= hdr_wr_data;
    end
  end

  // Read tag FIFO: 0 = hdr reader, 1 = vga reader
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      for (int i = 0; i < RD_DEPTH; i++) tags[i] <= 1'b0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (push) begin
        tags[tag_wr_ptr] <= grant_q[3];
        tag_wr_ptr       <= tag_wr_ptr + 1'b1;
      end
      if (pop) tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      hdr_rd_valid <= 1'b0;
      vga_rd_valid <= 1'b0;
      hdr_rd_data  <= '0;
      vga_rd_data  <= '0;
      rd_underflow <= 1'b0;
    end else begin
      hdr_rd_valid <= pop & ~pop_tag;
      vga_rd_valid <= pop & pop_tag;
      if (pop && !pop_tag) hdr_rd_data <= ram_rd_data;
      if (pop && pop_tag)  vga_rd_data <= ram_rd_data;
      rd_underflow <= (rd_underflow & ~err_clr) | (ram_rd_valid & (tag_cnt == '0));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_arbiter: directed self-checking bench for ram_arbiter.            |
// |                                                            Revision 1.0  |
// +--------------------------------------------------------------------------+
module tb_ram_arbiter;

  localparam int AW = 25;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_wr_req = 0, hdr_wr_req = 0, hdr_rd_req = 0, vga_rd_req = 0;
  logic [AW-1:0] cam_wr_address = '0, hdr_wr_address = '0;
  logic [AW-1:0] hdr_rd_address = '0, vga_rd_address = '0;
  logic [DW-1:0] cam_wr_data = '0, hdr_wr_data = '0, ram_rd_data = '0;
  logic          ram_busy = 0, ram_rd_valid = 0, err_clr = 0;
  logic          cmd_req, cmd_we, hdr_rd_valid, vga_rd_valid, rd_underflow;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_data, hdr_rd_data, vga_rd_data;
  logic [3:0]    grant, pending, overflow;

  int checks   = 0;
  int failures = 0;
  logic seen;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(4), .ISSUE_GAP(2)) dut (
    .clk_133M(clk), .rst_133M(rst),
    .cam_wr_req(cam_wr_req), .cam_wr_address(cam_wr_address), .cam_wr_data(cam_wr_data),
    .hdr_wr_req(hdr_wr_req), .hdr_wr_address(hdr_wr_address), .hdr_wr_data(hdr_wr_data),
    .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address),
    .vga_rd_req(vga_rd_req), .vga_rd_address(vga_rd_address),
    .ram_busy(ram_busy), .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .err_clr(err_clr),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .grant(grant), .hdr_rd_valid(hdr_rd_valid), .hdr_rd_data(hdr_rd_data),
    .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
    .pending(pending), .overflow(overflow), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    chk("rst_cmd_req", cmd_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", rd_underflow, 0);
    rst = 1'b0;
    step(5);

    // single camera write: pulse at t, command at t+2
    cam_wr_address = 25'h96000;
    cam_wr_data    = {16{8'hA5}};
    cam_wr_req = 1; step; cam_wr_req = 0;
    chk("cam_pending", pending, 4'b0001);
    chk("cam_early", cmd_req, 0);
    step;
    chk("cam_cmd_req", cmd_req, 1);
    chk("cam_we", cmd_we, 1);
    chk("cam_addr", cmd_address, 25'h96000);
    chk("cam_data", cmd_data, {16{8'hA5}});
    chk("cam_grant", grant, 4'b0001);
    step;
    chk("cam_pend_clr", pending, 4'b0000);
    chk("cam_req_clr", cmd_req, 0);
    step(6);

    // all four at once
    cam_wr_address = 25'h100; cam_wr_data = 128'h1111;
    hdr_wr_address = 25'h200; hdr_wr_data = 128'h2222;
    hdr_rd_address = 25'h300; vga_rd_address = 25'h400;
    cam_wr_req = 1; hdr_wr_req = 1; hdr_rd_req = 1; vga_rd_req = 1;
    step;
    cam_wr_req = 0; hdr_wr_req = 0; hdr_rd_req = 0; vga_rd_req = 0;
    chk("all_pending", pending, 4'b1111);
    step;
    chk("all_g0", grant, 4'b0001);
    chk("all_a0", cmd_address, 25'h100);
    step(3);
    chk("all_gap", cmd_req, 0);
    step;
    chk("all_g1", grant, 4'b0010);
    chk("all_a1", cmd_address, 25'h200);
    chk("all_d1", cmd_data, 128'h2222);
    step(4);
    chk("all_g2", grant, 4'b0100);
    chk("all_we2", cmd_we, 0);
    chk("all_d2", cmd_data, 0);
    chk("all_a2", cmd_address, 25'h300);
    step(4);
    chk("all_g3", grant, 4'b1000);
    chk("all_a3", cmd_address, 25'h400);
    step;
    chk("all_pend_clr", pending, 4'b0000);
    step(5);

    // rotation continues from hdr_wr
    hdr_wr_address = 25'h210; hdr_rd_address = 25'h310; vga_rd_address = 25'h410;
    hdr_wr_req = 1; hdr_rd_req = 1; vga_rd_req = 1;
    step;
    hdr_wr_req = 0; hdr_rd_req = 0; vga_rd_req = 0;
    step;
    chk("rot_g0", grant, 4'b0010);
    chk("rot_a0", cmd_address, 25'h210);
    step(4);
    chk("rot_g1", grant, 4'b0100);
    step(4);
    chk("rot_g2", grant, 4'b1000);
    step(5);

    // four outstanding reads return in order hdr, vga, hdr, vga
    ram_rd_valid = 1; ram_rd_data = 128'hD0;
    step; ram_rd_data = 128'hD1;
    chk("ret0_hv", hdr_rd_valid, 1);
    chk("ret0_hd", hdr_rd_data, 128'hD0);
    chk("ret0_vv", vga_rd_valid, 0);
    step; ram_rd_data = 128'hD2;
    chk("ret1_vv", vga_rd_valid, 1);
    chk("ret1_vd", vga_rd_data, 128'hD1);
    chk("ret1_hv", hdr_rd_valid, 0);
    step; ram_rd_data = 128'hD3;
    chk("ret2_hv", hdr_rd_valid, 1);
    chk("ret2_hd", hdr_rd_data, 128'hD2);
    step; ram_rd_valid = 0;
    chk("ret3_vv", vga_rd_valid, 1);
    chk("ret3_vd", vga_rd_data, 128'hD3);
    chk("ret3_uf", rd_underflow, 0);
    step;
    chk("ret_idle_hv", hdr_rd_valid, 0);
    chk("ret_idle_vv", vga_rd_valid, 0);

    // extra return underflows
    ram_rd_valid = 1; ram_rd_data = 128'hEE;
    step; ram_rd_valid = 0;
    chk("uf_set", rd_underflow, 1);
    chk("uf_hv", hdr_rd_valid, 0);
    chk("uf_vv", vga_rd_valid, 0);
    // new error alongside err_clr keeps the flag
    err_clr = 1; ram_rd_valid = 1;
    step; ram_rd_valid = 0;
    chk("uf_clr_race", rd_underflow, 1);
    step; err_clr = 0;
    chk("uf_clr", rd_underflow, 0);

    // busy controller blocks issue; repeat pulse overflows
    ram_busy = 1; hdr_rd_address = 25'h330;
    hdr_rd_req = 1; step; hdr_rd_req = 0;
    chk("busy_pend", pending, 4'b0100);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hdr_rd_req = (i == 5);
      if (i == 5) hdr_rd_address = 25'h777;
      step;
      if (cmd_req) seen = 1'b1;
    end
    hdr_rd_req = 0;
    chk("busy_noissue", seen, 0);
    chk("busy_ovf", overflow, 4'b0100);
    ram_busy = 0;
    step;
    chk("busy_issue", cmd_req, 1);
    chk("busy_grant", grant, 4'b0100);
    chk("busy_addr", cmd_address, 25'h330);
    err_clr = 1; step; err_clr = 0;
    chk("ovf_clr", overflow, 0);
    ram_rd_valid = 1; ram_rd_data = 128'hD4;
    step; ram_rd_valid = 0;
    chk("busy_ret_hv", hdr_rd_valid, 1);
    chk("busy_ret_hd", hdr_rd_data, 128'hD4);
    step(4);

    // fill the tag FIFO (pointer now favours vga)
    hdr_rd_req = 1; vga_rd_req = 1; step; hdr_rd_req = 0; vga_rd_req = 0;
    step;
    chk("fill_g0", grant, 4'b1000);
    step(4);
    chk("fill_g1", grant, 4'b0100);
    step(4);
    hdr_rd_req = 1; vga_rd_req = 1; step; hdr_rd_req = 0; vga_rd_req = 0;
    step;
    chk("fill_g2", grant, 4'b1000);
    step(4);
    chk("fill_g3", grant, 4'b0100);
    step(4);
    cam_wr_address = 25'h500;
    cam_wr_req = 1; vga_rd_req = 1; step; cam_wr_req = 0; vga_rd_req = 0;
    step;
    chk("full_cam", grant, 4'b0001);
    chk("full_cam_a", cmd_address, 25'h500);
    step(4);
    chk("full_block", cmd_req, 0);
    chk("full_pend", pending, 4'b1000);
    step(2);
    ram_rd_valid = 1; ram_rd_data = 128'hD5;
    step; ram_rd_valid = 0;
    chk("full_ret_vv", vga_rd_valid, 1);
    chk("full_ret_vd", vga_rd_data, 128'hD5);
    chk("full_wait", cmd_req, 0);
    step;
    chk("full_vga_issue", grant, 4'b1000);
    ram_rd_valid = 1; ram_rd_data = 128'hD6;
    step; ram_rd_data = 128'hD7;
    chk("drain_hd", hdr_rd_data, 128'hD6);
    step; ram_rd_valid = 0;
    chk("drain_vv", vga_rd_valid, 1);
    chk("drain_vd", vga_rd_data, 128'hD7);
    step(2);

    // async reset during HOLD, 2 reads outstanding, 2 slots pending
    cam_wr_req = 1; hdr_wr_req = 1; hdr_rd_req = 1;
    step; cam_wr_req = 0; hdr_wr_req = 0; hdr_rd_req = 0;
    step;
    chk("hold_issue", grant, 4'b0001);
    step;
    chk("hold_pend", pending, 4'b0110);
    #2 rst = 1'b1;
    #1;
    chk("arst_pending", pending, 0);
    chk("arst_cmd_req", cmd_req, 0);
    chk("arst_we", cmd_we, 0);
    chk("arst_addr", cmd_address, 0);
    chk("arst_hd", hdr_rd_data, 0);
    chk("arst_vd", vga_rd_data, 0);
    step(2);
    rst = 1'b0;
    step;
    ram_rd_valid = 1; step; ram_rd_valid = 0;
    chk("stray_uf", rd_underflow, 1);
    chk("stray_hv", hdr_rd_valid, 0);
    chk("stray_vv", vga_rd_valid, 0);
    step(4);
    chk("post_rst_idle", cmd_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
